// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - RV32I load/store unit controller with alignment, lane steering and timeout
module lsu_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] rdata_out,
    output logic        rdata_valid,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    f3_q;
    logic [1:0]    off_q;

    logic          illegal;
    logic          misaligned;
    logic          accept;
    logic [3:0]    be_next;
    logic [31:0]   wdata_next;
    logic [31:0]   load_data;
    logic [31:0]   byte_shift;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;

    // Decode the presented request: legality, alignment, store lane steering
    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        be_next    = 4'hF;
        wdata_next = 32'h0;
        if (req_we)
            illegal = req_funct3[2] | (req_funct3[1:0] == 2'b11);
        else
            illegal = (req_funct3 == 3'b011) | (req_funct3[2:1] == 2'b11);
        misaligned = ((req_funct3[1:0] == 2'b01) & req_addr[0]) |
                     ((req_funct3[1:0] == 2'b10) & (req_addr[1:0] != 2'b00));
        if (req_we) begin
            case (req_funct3[1:0])
                2'b00: begin
                    be_next    = 4'b0001 << req_addr[1:0];
                    wdata_next = {4{req_wdata[7:0]}};
                end
                2'b01: begin
                    be_next    = 4'b0011 << {req_addr[1], 1'b0};
                    wdata_next = {2{req_wdata[15:0]}};
                end
                default: begin
                    be_next    = 4'hF;
                    wdata_next = req_wdata;
                end
            endcase
        end
        accept = (state == IDLE) & req_valid & ~illegal & ~misaligned;
        stall  = (state == REQ) | accept;
    end

    // Pick the addressed byte/half out of the returned word and extend it
    always_comb begin
        byte_shift = mem_rdata >> {off_q, 3'b000};
        byte_sel   = byte_shift[7:0];
        half_sel   = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_data = {24'h0, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_data = {16'h0, half_sel};
            default: load_data = mem_rdata;
        endcase
    end

    // Request FSM: accept in IDLE, hold the bus in REQ, report in DONE
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            f3_q        <= 3'b000;
            off_q       <= 2'b00;
            rdata_out   <= 32'h0;
            rdata_valid <= 1'b0;
            err         <= 1'b0;
            err_code    <= 2'b00;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 32'h0;
            mem_wdata   <= 32'h0;
            mem_be      <= 4'h0;
        end else begin
            err         <= 1'b0;
            err_code    <= 2'b00;
            rdata_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (illegal) begin
                            err      <= 1'b1;
                            err_code <= 2'b11;
                        end else if (misaligned) begin
                            err      <= 1'b1;
                            err_code <= 2'b01;
                        end else begin
                            state     <= REQ;
                            cnt       <= '0;
                            f3_q      <= req_funct3;
                            off_q     <= req_addr[1:0];
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_wdata <= wdata_next;
                            mem_be    <= be_next;
                        end
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        state       <= DONE;
                        mem_req     <= 1'b0;
                        rdata_valid <= 1'b1;
                        rdata_out   <= mem_we ? 32'h0 : load_data;
                    end else if (cnt == CNT_LAST) begin
                        state       <= DONE;
                        mem_req     <= 1'b0;
                        rdata_valid <= 1'b1;
                        rdata_out   <= 32'h0;
                        err         <= 1'b1;
                        err_code    <= 2'b10;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    rdata_out <= 32'h0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - scoreboard bench for lsu_ctrl
module tb_lsu_ctrl;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic [31:0] rdata_out;
    logic        rdata_valid;
    logic        err;
    logic [1:0]  err_code;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [1:0]  code;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   valid_seen = 0;

    lsu_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .rdata_out(rdata_out), .rdata_valid(rdata_valid),
        .err(err), .err_code(err_code), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] model_be(input logic we, input logic [2:0] f3, input logic [31:0] a);
        if (!we) return 4'hF;
        if (f3 == 3'b000) return 4'(1 << a[1:0]);
        if (f3 == 3'b001) return a[1] ? 4'b1100 : 4'b0011;
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(input logic we, input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        if (!we) return 32'h0;
        for (int l = 0; l < 4; l++) begin
            if (f3 == 3'b000)      r[8*l +: 8] = wd[7:0];
            else if (f3 == 3'b001) r[8*l +: 8] = wd[8*(l%2) +: 8];
            else                   r[8*l +: 8] = wd[8*l +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        int          lane;
        lane = int'(a[1:0]);
        b = rd[8*lane +: 8];
        h = rd[16*(lane/2) +: 16];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            default: return rd;
        endcase
    endfunction

    // Pop one expected completion each time the DUT strobes rdata_valid
    always @(negedge clk) begin
        if (rdata_valid) begin
            valid_seen++;
            if (sb.size() == 0) begin
                check("unexpected_rdata_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rdata_out", rdata_out, e.rdata);
                check("done_err", {31'h0, err}, {31'h0, e.err});
                check("done_err_code", {30'h0, err_code}, {30'h0, e.code});
            end
        end
    end

    // ack_at: REQ cycle (1-based) carrying mem_ack; 0 means never ack
    task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] rd, input int ack_at);
        int   n;
        int   sc;
        int   vs;
        exp_t e;
        logic [3:0]  eb;
        logic [31:0] ew;
        eb = model_be(we, f3, a);
        ew = model_wdata(we, f3, wd);
        e.err   = (ack_at == 0);
        e.code  = (ack_at == 0) ? 2'b10 : 2'b00;
        e.rdata = (ack_at == 0 || we) ? 32'h0 : model_load(f3, a, rd);
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        sb.push_back(e);
        vs = valid_seen;
        #1;
        check("accept_stall", {31'h0, stall}, 32'd1);
        sc = 1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (n < TO) begin
            n++;
            if (n == ack_at) begin
                mem_ack = 1'b1;
                mem_rdata = rd;
            end
            #1;
            if (stall) sc++;
            check("mem_req", {31'h0, mem_req}, 32'd1);
            check("mem_addr", mem_addr, {a[31:2], 2'b00});
            if (n == 1) begin
                check("mem_we", {31'h0, mem_we}, {31'h0, we});
                check("mem_be", {28'h0, mem_be}, {28'h0, eb});
                check("mem_wdata", mem_wdata, ew);
            end
            @(posedge clk); #1;
            mem_ack = 1'b0;
            if (n == ack_at) break;
        end
        check("done_mem_req", {31'h0, mem_req}, 32'd0);
        check("done_stall", {31'h0, stall}, 32'd0);
        check("stall_cycles", sc, (ack_at == 0) ? TO + 1 : ack_at + 1);
        @(posedge clk); #1;
        check("valid_strobes", valid_seen - vs, 32'd1);
    endtask

    task automatic do_bad(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [1:0] code);
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = 32'h1234_5678;
        #1;
        check("bad_stall_comb", {31'h0, stall}, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("bad_err", {31'h0, err}, 32'd1);
        check("bad_err_code", {30'h0, err_code}, {30'h0, code});
        check("bad_mem_req", {31'h0, mem_req}, 32'd0);
        check("bad_stall", {31'h0, stall}, 32'd0);
        @(posedge clk); #1;
        check("bad_err_pulse", {31'h0, err}, 32'd0);
        check("bad_mem_req2", {31'h0, mem_req}, 32'd0);
    endtask

    initial begin
        logic [2:0]  legal_ld[5];
        logic [2:0]  f3;
        logic [31:0] a;
        logic        we;
        int          vs;
        legal_ld = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_req", {31'h0, mem_req}, 32'd0);
        check("rst_stall", {31'h0, stall}, 32'd0);
        check("rst_rdata_valid", {31'h0, rdata_valid}, 32'd0);
        check("rst_err", {31'h0, err}, 32'd0);
        check("rst_mem_be", {28'h0, mem_be}, 32'd0);
        reset = 1'b1;

        do_access(1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_1234, 1);
        do_access(1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 3);
        do_bad(1'b0, 3'b010, 32'h0000_0006, 2'b01);
        do_access(1'b0, 3'b010, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 0);
        do_bad(1'b0, 3'b110, 32'h0000_0010, 2'b11);
        do_bad(1'b1, 3'b011, 32'h0000_0010, 2'b11);
        do_bad(1'b1, 3'b001, 32'h0000_0011, 2'b01);
        do_access(1'b0, 3'b101, 32'h0000_0302, 32'h0, 32'h8765_4321, TO);
        do_access(1'b1, 3'b000, 32'h0000_0401, 32'h0000_00A5, 32'hFFFF_FFFF, 2);

        // Reset in the middle of REQ; the late ack must be ignored
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0500;
        vs = valid_seen;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rst_mid_req_before", {31'h0, mem_req}, 32'd1);
        reset = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_mem_req", {31'h0, mem_req}, 32'd0);
        check("rst_mid_stall", {31'h0, stall}, 32'd0);
        check("rst_mid_err", {31'h0, err}, 32'd0);
        reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
        repeat (3) @(posedge clk);
        #1;
        mem_ack = 1'b0;
        check("rst_ack_ignored_req", {31'h0, mem_req}, 32'd0);
        check("rst_no_valid", valid_seen - vs, 32'd0);

        for (int i = 0; i < 8; i++) begin
            we = 1'($urandom_range(0, 1));
            f3 = we ? 3'($urandom_range(0, 2)) : legal_ld[$urandom_range(0, 4)];
            a = $urandom & 32'hFFFF_FFFC;
            if (f3[1:0] == 2'b00) a[1:0] = 2'($urandom_range(0, 3));
            else if (f3[1:0] == 2'b01) a[1] = 1'($urandom_range(0, 1));
            do_access(we, f3, a, $urandom, $urandom, $urandom_range(1, 5));
        end

        repeat (3) @(posedge clk);
        check("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL give the maximum number of cycles spent in REQ waiting for mem_ack.
REQ-002 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 reset  in  1  SHALL be a synchronous, active-low reset.
REQ-004 req_valid  in  1  SHALL indicate that the core presents a load/store this cycle.
REQ-005 req_we  in  1  SHALL select the access type: 1 = store, 0 = load.
REQ-006 req_funct3  in  3  SHALL carry the RV32I width/sign code (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010).
REQ-007 req_addr  in  32  SHALL carry the byte address (ALU result).
REQ-008 req_wdata  in  32  SHALL carry the store data (rs2).
REQ-009 stall  out  1  SHALL freeze the core PC and register write while asserted.
REQ-010 rdata_out  out  32  SHALL carry the extended load result.
REQ-011 rdata_valid  out  1  SHALL be a one-cycle completion strobe.
REQ-012 err  out  1 and err_code  out  2  SHALL report errors: 01 misaligned, 10 timeout, 11 illegal funct3.
REQ-013 mem_req  out  1, mem_we  out  1, mem_addr  out  32, mem_wdata  out  32, mem_be  out  4  SHALL form the memory request.
REQ-014 mem_ack  in  1 and mem_rdata  in  32  SHALL form the memory response.

Function
REQ-015 The FSM SHALL have three states: IDLE, REQ and DONE.
REQ-016 IDLE, with req_valid=1 and a legal, aligned access: the block SHALL latch the request and enter REQ; stall SHALL be 1 combinationally in this cycle.
REQ-017 Illegal funct3 (load 011/110/111; store >=011): the block SHALL pulse err with code 11 for one cycle, stay IDLE, keep stall=0 and issue no memory access.
REQ-018 Misaligned access (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0): the block SHALL pulse err with code 01 for one cycle, stay IDLE, keep stall=0 and issue no memory access.
REQ-019 In REQ: mem_req=1 and stall=1; mem_we, mem_addr ({addr[31:2],2'b00}), mem_wdata and mem_be SHALL hold stable until mem_ack or timeout.
REQ-020 REQ with mem_ack=1: the block SHALL capture mem_rdata in that cycle, drop mem_req on the next edge and enter DONE.
REQ-021 A timeout counter SHALL clear on entry to REQ and increment each REQ cycle without ack; when it reaches TIMEOUT-1 with no ack, the block SHALL enter DONE with err code 10 and rdata_out=0.
REQ-022 mem_ack arriving on the same cycle the counter reaches TIMEOUT-1 SHALL win: normal completion, no error.
REQ-023 DONE: rdata_valid=1, stall=0 and err asserted if a timeout occurred; req_valid SHALL be ignored and the next state SHALL be IDLE.
REQ-024 Store lanes: SB SHALL drive be=0001<<addr[1:0] with wdata={4{byte}}; SH SHALL drive be=0011<<{addr[1],1'b0} with wdata={2{half}}; SW SHALL drive be=1111.
REQ-025 Loads SHALL drive mem_be=1111 and mem_wdata=0.
REQ-026 Load extraction: a byte or half SHALL be selected by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes the full word.
REQ-027 Stores SHALL drive rdata_out=0 while rdata_valid=1.
REQ-028 mem_ack outside REQ SHALL be ignored.

Reset
REQ-029 When reset=0 at a clock edge: state IDLE, counter 0, and all outputs 0 on the following cycle, including mid-REQ; any pending mem_ack SHALL be ignored thereafter.

Verification
REQ-030 The bench SHALL cover the following directed scenarios:
- LB, addr 0x103, mem_rdata 0x80FF_1234 -> mem_addr 0x100, be 1111, rdata_out 0xFFFFFF80 on rdata_valid.
- SH, addr 0x202, wdata 0x0000_ABCD, ack after 3 cycles -> be 1100, mem_wdata 0xABCDABCD, stall high for 4 cycles, then rdata_valid.
- LW, addr 0x06 -> err=1 with code 01 for one cycle, mem_req stays 0, stall 0.
- LW with no ack, TIMEOUT=16 -> mem_req drops after 16 REQ cycles, DONE with err code 10, rdata_out 0.
- reset=0 during REQ, then ack -> mem_req 0 next cycle, no rdata_valid.
- funct3 110 load -> err code 11, no access.
